// File: rtl/lab5.sv
// lab5: fixed birthday digit ROM (19990815) addressed by sel.
// out is a pure sum-of-products decode of sel; out_q and seg are the
// registered digit and its seven-segment pattern (a..g on seg[6:0]).
module lab5 (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] sel,
    output logic [3:0] out,
    output logic [3:0] out_q,
    output logic [6:0] seg
);

    // Digit table, sel -> BCD:
    //   sel : 0 1 2 3 4 5 6 7
    //   out : 1 9 9 9 0 8 1 5
    // Bit 3 is set for sel 1,2,3,5; bit 2 only for sel 7; bit 1 never;
    // bit 0 for sel 0,1,2,3,6,7. The equations below are the minimised
    // sum-of-products covers of those minterm sets.
    logic s2;
    logic s1;
    logic s0;

    assign s2 = sel[2];
    assign s1 = sel[1];
    assign s0 = sel[0];

    // Combinational digit decode, independent of CLK and RST
    assign out[3] = (~s2 & s1) | (~s1 & s0);
    assign out[2] = s2 & s1 & s0;
    assign out[1] = 1'b0;
    assign out[0] = ~s2 | s1;

    // Standard active-high seven-segment pattern, seg[6]=a .. seg[0]=g.
    // Codes 10..15 are blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        p = 7'h00;
        case (d)
            4'd0:    p = 7'h7E;
            4'd1:    p = 7'h30;
            4'd2:    p = 7'h6D;
            4'd3:    p = 7'h79;
            4'd4:    p = 7'h33;
            4'd5:    p = 7'h5B;
            4'd6:    p = 7'h5F;
            4'd7:    p = 7'h70;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h7B;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    // Register the digit and its pattern together; reset blanks both and wins over the load
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q <= 4'd0;
            seg   <= 7'h00;
        end else begin
            out_q <= out;
            seg   <= seg_decode(out);
        end
    end

endmodule

// File: tb/tb_lab5.sv
// tb_lab5: directed table-driven checks plus a random sel run for lab5.
module tb_lab5;

    logic       CLK;
    logic       RST;
    logic [2:0] sel;
    logic [3:0] out;
    logic [3:0] out_q;
    logic [6:0] seg;

    int n_total = 0;
    int n_pass  = 0;

    lab5 dut (
        .CLK   (CLK),
        .RST   (RST),
        .sel   (sel),
        .out   (out),
        .out_q (out_q),
        .seg   (seg)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: birthday digits and seven-segment patterns as lookup tables
    logic [3:0] digit_tab [8];
    logic [6:0] seg_tab   [16];

    initial begin
        digit_tab = '{4'd1, 4'd9, 4'd9, 4'd9, 4'd0, 4'd8, 4'd1, 4'd5};
        seg_tab   = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                      7'h7F, 7'h7B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    end

    // Scoreboard queue of expected registered digits
    logic [3:0] exp_q [$];

    typedef struct {
        logic       rst;
        logic [2:0] sel;
        logic [3:0] exp_out;
        logic [3:0] exp_oq;
        logic [6:0] exp_seg;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Drive one vector before an edge, then check out before and out_q/seg after
    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge CLK);
        RST = v.rst;
        sel = v.sel;
        #1;
        check($sformatf("vec%0d_out", idx), {4'h0, out}, {4'h0, v.exp_out});
        @(posedge CLK);
        #1;
        check($sformatf("vec%0d_out_q", idx), {4'h0, out_q}, {4'h0, v.exp_oq});
        check($sformatf("vec%0d_seg", idx), {1'b0, seg}, {1'b0, v.exp_seg});
        check($sformatf("vec%0d_out_hold", idx), {4'h0, out}, {4'h0, v.exp_out});
    endtask

    initial begin
        logic [3:0] prev_q;
        logic [3:0] e;
        logic [2:0] r;

        RST = 1'b1;
        sel = 3'd0;

        // rst sel   out   out_q seg
        vecs[0]  = '{1'b1, 3'd1, 4'd9, 4'd0, 7'h00};  // reset held, out follows sel
        vecs[1]  = '{1'b1, 3'd1, 4'd9, 4'd0, 7'h00};
        vecs[2]  = '{1'b0, 3'd7, 4'd5, 4'd5, 7'h5B};  // first load after reset
        vecs[3]  = '{1'b0, 3'd0, 4'd1, 4'd1, 7'h30};  // wrap 7 -> 0
        vecs[4]  = '{1'b0, 3'd1, 4'd9, 4'd9, 7'h7B};
        vecs[5]  = '{1'b0, 3'd2, 4'd9, 4'd9, 7'h7B};
        vecs[6]  = '{1'b0, 3'd3, 4'd9, 4'd9, 7'h7B};
        vecs[7]  = '{1'b0, 3'd4, 4'd0, 4'd0, 7'h7E};
        vecs[8]  = '{1'b0, 3'd5, 4'd8, 4'd8, 7'h7F};
        vecs[9]  = '{1'b0, 3'd6, 4'd1, 4'd1, 7'h30};
        vecs[10] = '{1'b0, 3'd7, 4'd5, 4'd5, 7'h5B};
        vecs[11] = '{1'b0, 3'd5, 4'd8, 4'd8, 7'h7F};  // sel=5 held
        vecs[12] = '{1'b0, 3'd1, 4'd9, 4'd9, 7'h7B};
        vecs[13] = '{1'b0, 3'd2, 4'd9, 4'd9, 7'h7B};  // mid-sweep
        vecs[14] = '{1'b1, 3'd3, 4'd9, 4'd0, 7'h00};  // reset wins over load
        vecs[15] = '{1'b0, 3'd3, 4'd9, 4'd9, 7'h7B};
        vecs[16] = '{1'b0, 3'd4, 4'd0, 4'd0, 7'h7E};
        vecs[17] = '{1'b0, 3'd6, 4'd1, 4'd1, 7'h30};
        vecs[18] = '{1'b0, 3'd0, 4'd1, 4'd1, 7'h30};

        // Combinational sweep under reset: out must follow sel with no edge involved
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            sel = i[2:0];
            #1;
            check($sformatf("comb_sel%0d", i), {4'h0, out}, {4'h0, digit_tab[i]});
            #2;
            check($sformatf("comb_sel%0d_late", i), {4'h0, out}, {4'h0, digit_tab[i]});
        end
        @(posedge CLK);
        #1;
        check("reset_out_q", {4'h0, out_q}, 8'h00);
        check("reset_seg", {1'b0, seg}, 8'h00);

        // Directed table
        for (int i = 0; i < 19; i++)
            apply_vec(vecs[i], i);

        // Lag check: between a sel change and the next edge out_q keeps its old value
        @(negedge CLK);
        RST = 1'b0;
        sel = 3'd7;
        #1;
        check("lag_before_edge", {4'h0, out_q}, 8'h01);
        check("lag_out_now", {4'h0, out}, 8'h05);
        @(posedge CLK);
        #1;
        check("lag_after_edge", {4'h0, out_q}, 8'h05);
        check("lag_seg_after_edge", {1'b0, seg}, 8'h5B);

        // Random sel every cycle against the table model with a one-cycle scoreboard
        prev_q = 4'd5;
        for (int c = 0; c < 1000; c++) begin
            @(negedge CLK);
            r = 3'($urandom_range(0, 7));
            sel = r;
            #1;
            check("rand_out", {4'h0, out}, {4'h0, digit_tab[r]});
            check("rand_hold", {4'h0, out_q}, {4'h0, prev_q});
            exp_q.push_back(digit_tab[r]);
            @(posedge CLK);
            #1;
            if (exp_q.size() == 0) begin
                check("rand_queue_empty", 8'h01, 8'h00);
            end else begin
                e = exp_q.pop_front();
                check("rand_out_q", {4'h0, out_q}, {4'h0, e});
                check("rand_seg", {1'b0, seg}, {1'b0, seg_tab[e]});
                prev_q = e;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lab5.md
LAB5 -- requirements
Module: lab5

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL update only on the rising edge of CLK.
REQ-002 Port: CLK  input  1  system clock, rising-edge active.
REQ-003 Port: RST  input  1  synchronous active-high reset, sampled on the CLK rising edge.
REQ-004 Port: sel  input  3  digit index 0..7 into the stored birthday string.
REQ-005 Port: out  output  4  combinational BCD digit selected by sel.
REQ-006 Port: out_q  output  4  registered copy of out.
REQ-007 Port: seg  output  7  registered seven-segment pattern of out_q, active-high, seg[6]=a down to seg[0]=g.
REQ-008 Parameters: none; the birthday digit table SHALL be fixed in logic.

Function
REQ-009 The birthday string SHALL be 1,9,9,9,0,8,1,5 for sel = 0,1,2,3,4,5,6,7 (YYYYMMDD = 19990815).
REQ-010 out SHALL be purely combinational from sel with zero-cycle latency, built structurally from gate primitives (AND/OR/NOT) or sum-of-products per output bit; no procedural case table.
REQ-011 Per-bit equations SHALL produce exactly the REQ-009 table for all 8 sel codes; no sel value is invalid.
REQ-012 out SHALL NOT depend on CLK or RST.
REQ-013 out_q SHALL load out on every rising CLK edge when RST=0: one-cycle latency from sel to out_q.
REQ-014 seg SHALL be the standard decimal pattern of the 4-bit value registered into out_q, updated on the same edge as out_q: 0=7E, 1=30, 5=5B, 8=7F, 9=7B, other digits per standard seven-segment encoding.
REQ-015 Codes 10..15 SHALL decode to blank (seg=00); unreachable in normal operation, defined for completeness.
REQ-016 sel changing every cycle SHALL give out_q and seg tracking sel delayed by exactly one cycle, with no skipped or repeated digits.
REQ-017 sel wrap from 7 to 0 SHALL need no special handling: out goes 5 -> 1 combinationally.
REQ-018 sel and out SHALL behave as specified at every bit width with no X propagation when sel is known.

Reset
REQ-019 When RST=1 at a rising CLK edge, out_q SHALL become 0 and seg SHALL become 00 (blank), regardless of sel.
REQ-020 While RST is held high, out SHALL continue to follow sel combinationally.
REQ-021 On the first rising edge with RST=0 after reset, out_q SHALL load the current out and seg its pattern.
REQ-022 Reset asserted mid-sequence SHALL override the load on that edge: reset wins.

Verification
REQ-023 Sweep sel 0..7 with no clock -> out = 1,9,9,9,0,8,1,5 combinationally.
REQ-024 RST=1 for 2 cycles with sel=1 -> out_q=0, seg=00 and out=9 throughout.
REQ-025 Release reset, increment sel each cycle from 7 wrapping through 0..7 -> out_q lags out by one cycle: after the sel=7 edge out_q=5, seg=5B; after the sel=0 edge out_q=1, seg=30.
REQ-026 sel=5 held, one edge -> out_q=8, seg=7F; then sel=1, one edge -> out_q=9, seg=7B.
REQ-027 Assert RST for one edge while sel=3 mid-sweep -> out_q=0, seg=00 on that edge; next edge out_q=9.
REQ-028 Randomised sel over 1000 cycles checked against a REQ-009 table model -> out and the one-cycle-delayed out_q/seg always match.
